// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encodings
// and the default operand width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in, with borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_in_i,
    output logic diff_o,
    output logic borrow_out_o
);

    assign diff_o       = a_i ^ b_i ^ borrow_in_i;
    assign borrow_out_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_in_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b computed LSB first through one full-subtractor
// cell, with a start/ready/done handshake and a {borrow, difference} result.
//
// state | meaning
// IDLE  | ready high, waiting for start; operands latched on the accepting edge
// SHIFT | one bit processed per edge, LSB first
// DONE  | single-cycle done pulse, diff freshly loaded
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH:0]   diff_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic             bit_diff;
    logic             bit_bout;
    logic             last_bit;

    full_subtractor u_full_subtractor (
        .a_i          (a_sh_q[0]),
        .b_i          (b_sh_q[0]),
        .borrow_in_i  (borrow_q),
        .diff_o       (bit_diff),
        .borrow_out_o (bit_bout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE:    ready_o = 1'b1;
            DONE:    done_o  = 1'b1;
            default: ;
        endcase
    end

    // Result bits enter from the MSB side so the LSB-first stream lands in place.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_d    = {bit_diff, res_q[WIDTH-1:1]};
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d = {bit_bout, bit_diff, res_q[WIDTH-1:1]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
        end
    end

    assign diff_o = diff_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor, the inverse of the team's 4-bit ripple adder. It computes a - b one bit per clock, LSB first, through a single full-subtractor cell. The result has the same 5-bit shape as the adder's sum: {borrow, difference}. It sits beside the adder in the arithmetic datapath and uses a start/ready/done handshake so a controller can sequence operations.

Parameters:
WIDTH, 4, operand width in bits; the result is WIDTH+1 bits.

Ports:
clk  input  1  single system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only when ready=1
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
ready  output  1  high in IDLE; the block can accept start
done  output  1  one-cycle pulse; diff is valid and updated
diff  output  WIDTH+1  {borrow_out, (a-b) mod 2^WIDTH}; equals a-b as a (WIDTH+1)-bit two's-complement value

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE, ready=1, done=0, diff=0, internal operand/shift/borrow/counter registers=0.
- States and transitions:
  - IDLE: ready=1. If start=1 at an edge: latch a->a_sh and b->b_sh, clear borrow, clear bit counter, go to SHIFT.
  - SHIFT: ready=0. Each edge:
    - Full subtractor takes a_sh[0], b_sh[0], borrow.
    - d = a^b^bin.
    - bout = (~a&b) | (~(a^b)&bin).
    - d is shifted into the result shift register from the MSB side.
    - borrow<=bout; a_sh and b_sh shift right; counter increments.
    - On the edge that processes bit WIDTH-1, go to DONE and load diff <= {bout, final shifted result}.
  - DONE: ready=0, done=1 for exactly this cycle. The next edge goes to IDLE.
- Latency:
  - Start accepted at edge N; done is high in the cycle following edge N+WIDTH.
  - Issue interval is WIDTH+2 cycles.
- diff is a holding register. It changes only on the transition into DONE (and on reset), so partial results are never visible. It holds its value until the next completion.
- start while ready=0 is ignored (not queued). start held high continuously starts a new operation on every IDLE cycle.
- a and b may change freely after the accepting edge without affecting the result.
- Width rule: diff[WIDTH] is the final borrow, set when a<b unsigned. Example: 3-5 -> 5'b11110 (-2).
- rst mid-operation: aborts on that edge, returns to IDLE with reset values. diff is cleared to 0 and no done pulse is produced.
- rst and start in the same cycle: rst wins; the start is dropped.
- Counter width: clog2(WIDTH)+1 bits; no wrap occurs within an operation.

Decomposition:
- Shared header/package holds the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default operand width constant (4). The adder and future arithmetic blocks reuse it.
- One natural sub-module: full_subtractor, a 1-bit combinational cell with ports a, b, borrow_in, diff, borrow_out. It is the counterpart of the adder's full_adder.
- FSM, shift registers and counter live in serial_subtractor.

Test Plan:
- Reset, then start with a=9, b=3 -> ready drops next cycle; done pulses exactly 4 cycles after the accepting edge with diff=5'b00110; ready returns high the cycle after done.
- a=3, b=5 -> diff=5'b11110 (borrow=1, -2 two's complement); a=0, b=15 -> diff=5'b10001; a=15, b=0 -> diff=5'b01111.
- Start a=7, b=7; during SHIFT pulse start with a=1, b=0 and change a/b -> the extra start is ignored; result diff=5'b00000; exactly one done pulse.
- Assert rst two cycles into SHIFT (a=12, b=4) -> next cycle ready=1, done=0, diff=0; no done pulse follows; a subsequent start a=12, b=4 yields diff=5'b01000.
- Hold start high, operands cycling through a random sequence -> back-to-back operations every 6 cycles; each diff equals the scoreboard value {a<b, (a-b)&4'hF}.
- Exhaustive sweep of all 256 (a,b) pairs -> every diff matches (a-b) in 5-bit two's complement; diff never changes except on done cycles.
